// File: rtl/tap_atpg_entry.sv
// Serial TAP entry into scan/Iddq test modes: key, mode code and length, then payload forwarded to scan_do.
// Optional parity bit after the length field is enabled by defining TAP_PARITY_EN.
module tap_atpg_entry #(
  parameter logic [7:0] KEY   = 8'hA5,
  parameter int         LEN_W = 8
) (
  input  logic clk,
  input  logic rstb,
  input  logic tap_sel,
  input  logic tap_vld,
  input  logic tap_di,
  output logic mode_scan,
  output logic mode_iddq,
  output logic scan_do,
  output logic scan_vld,
  output logic busy,
  output logic err
);
  localparam int IW = $clog2(((LEN_W > 8) ? LEN_W : 8) + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_MODE, S_LEN, S_PAR, S_SHIFT, S_HOLD, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [7:0]         key_q, key_d;
  logic [2:0]         code_q, code_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               par_q, par_d;
  logic               mode_scan_q, mode_scan_d;
  logic               mode_iddq_q, mode_iddq_d;
  logic               scan_do_q, scan_do_d;
  logic               scan_vld_q, scan_vld_d;
  logic               err_q, err_d;

  logic [7:0]         key_nx;
  logic [2:0]         code_nx;
  logic [LEN_W-1:0]   cnt_nx;
  logic               par_nx;
  logic               go;
  logic [LEN_W-1:0]   go_len;

  assign key_nx  = {tap_di, key_q[7:1]};
  assign code_nx = {tap_di, code_q[2:1]};
  assign cnt_nx  = {tap_di, cnt_q[LEN_W-1:1]};
  assign par_nx  = par_q ^ tap_di;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    key_d       = key_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    mode_scan_d = mode_scan_q;
    mode_iddq_d = mode_iddq_q;
    scan_do_d   = scan_do_q;
    scan_vld_d  = 1'b0;
    err_d       = err_q;
    go          = 1'b0;
    go_len      = cnt_q;

    if (!tap_sel) begin
      // Abort dominates everything, including a header that completes this cycle.
      state_d     = S_IDLE;
      idx_d       = '0;
      key_d       = '0;
      code_d      = '0;
      cnt_d       = '0;
      par_d       = 1'b0;
      mode_scan_d = 1'b0;
      mode_iddq_d = 1'b0;
      if (state_q == S_IDLE) err_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_KEY;
          if (tap_vld) begin
            key_d = key_nx;
            par_d = par_nx;
            idx_d = IW'(1);
          end
        end
        S_KEY: if (tap_vld) begin
          key_d = key_nx;
          par_d = par_nx;
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(7)) begin
            idx_d = '0;
            if (key_nx == KEY) state_d = S_MODE;
            else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end
        end
        S_MODE: if (tap_vld) begin
          code_d = code_nx;
          par_d  = par_nx;
          idx_d  = idx_q + IW'(1);
          if (idx_q == IW'(2)) begin
            idx_d = '0;
            if (code_nx == 3'd1 || code_nx == 3'd2) state_d = S_LEN;
            else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end
        end
        S_LEN: if (tap_vld) begin
          cnt_d = cnt_nx;
          par_d = par_nx;
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(LEN_W - 1)) begin
            idx_d = '0;
`ifdef TAP_PARITY_EN
            state_d = S_PAR;
`else
            go      = 1'b1;
            go_len  = cnt_nx;
`endif
          end
        end
`ifdef TAP_PARITY_EN
        S_PAR: if (tap_vld) begin
          if (tap_di == par_q) go = 1'b1;
          else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
`endif
        S_SHIFT: if (tap_vld) begin
          scan_do_d  = tap_di;
          scan_vld_d = 1'b1;
          cnt_d      = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_HOLD;
        end
        default: ;
      endcase

      if (go) begin
        mode_scan_d = (code_q == 3'd1);
        mode_iddq_d = (code_q == 3'd2);
        state_d     = (go_len == '0) ? S_HOLD : S_SHIFT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      key_q       <= '0;
      code_q      <= '0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      mode_scan_q <= 1'b0;
      mode_iddq_q <= 1'b0;
      scan_do_q   <= 1'b0;
      scan_vld_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      key_q       <= key_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      mode_scan_q <= mode_scan_d;
      mode_iddq_q <= mode_iddq_d;
      scan_do_q   <= scan_do_d;
      scan_vld_q  <= scan_vld_d;
      err_q       <= err_d;
    end
  end

  assign mode_scan = mode_scan_q;
  assign mode_iddq = mode_iddq_q;
  assign scan_do   = scan_do_q;
  assign scan_vld  = scan_vld_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
endmodule

// File: tb/tb_tap_atpg_entry.sv
// Randomized sessions against a bit-queue reference model, plus directed scenarios with literal expectations.
module tb_tap_atpg_entry;
  localparam logic [7:0] KEY = 8'hA5;
  localparam int LW = 8;
`ifdef TAP_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int HDR = 11 + LW + PB;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic tap_sel = 1'b0;
  logic tap_vld = 1'b0;
  logic tap_di = 1'b0;
  logic mode_scan, mode_iddq, scan_do, scan_vld, busy, err;

  tap_atpg_entry #(.KEY(KEY), .LEN_W(LW)) dut (
    .clk(clk), .rstb(rstb), .tap_sel(tap_sel), .tap_vld(tap_vld), .tap_di(tap_di),
    .mode_scan(mode_scan), .mode_iddq(mode_iddq), .scan_do(scan_do),
    .scan_vld(scan_vld), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int pulses = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  // Reference model: the session is just the queue of accepted bits; outputs are derived from it.
  bit q[$];
  bit sess = 0, serr = 0, m_err = 0, e_do = 0, e_vld = 0, started = 0;

  function automatic int field(input int lo, input int w);
    int v = 0;
    for (int i = 0; i < w; i++) v |= int'(q[lo + i]) << i;
    return v;
  endfunction

  function automatic bit in_hold();
    return q.size() >= HDR && (q.size() - HDR) == field(11, LW);
  endfunction

  function automatic bit hdr_par();
    bit p = 0;
    for (int i = 0; i < HDR - 1; i++) p ^= q[i];
    return p;
  endfunction

  function automatic bit e_mode(input int code);
    return sess && !serr && q.size() >= HDR && field(8, 3) == code;
  endfunction

  always @(posedge clk) begin
    started = 1;
    e_vld = 0;
    if (!rstb) begin
      sess = 0; serr = 0; m_err = 0; e_do = 0; q.delete();
    end else if (!tap_sel) begin
      if (!sess) m_err = 0;
      sess = 0; serr = 0; q.delete();
    end else begin
      sess = 1;
      if (tap_vld && !serr && !in_hold()) begin
        if (q.size() >= HDR) begin
          e_vld = 1;
          e_do = tap_di;
        end
        q.push_back(tap_di);
        if (q.size() == 8 && field(0, 8) != int'(KEY)) serr = 1;
        if (q.size() == 11 && field(8, 3) != 1 && field(8, 3) != 2) serr = 1;
        if (PB == 1 && q.size() == HDR && q[HDR - 1] != hdr_par()) serr = 1;
        if (serr) m_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk1("model_mode_scan", mode_scan, e_mode(1));
      chk1("model_mode_iddq", mode_iddq, e_mode(2));
      chk1("model_scan_vld", scan_vld, e_vld);
      chk1("model_scan_do", scan_do, e_do);
      chk1("model_busy", busy, sess);
      chk1("model_err", err, m_err);
      if (scan_vld === 1'b1) pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit b);
    tap_vld = 1; tap_di = b;
    tick();
    tap_vld = 0; tap_di = 1'($urandom);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // abort_at / rst_at: index of the bit that is driven together with tap_sel low / rstb low (-1 = none).
  task automatic session(input logic [7:0] k, input logic [2:0] c, input int len, input int npay,
                         input bit bad_par, input int abort_at, input int rst_at);
    bit s[$];
    bit p = 0;
    for (int i = 0; i < 8; i++) s.push_back(k[i]);
    for (int i = 0; i < 3; i++) s.push_back(c[i]);
    for (int i = 0; i < LW; i++) s.push_back(len[i]);
    foreach (s[i]) p ^= s[i];
    p = p ^ bad_par;
`ifdef TAP_PARITY_EN
    s.push_back(p);
`endif
    repeat (npay) s.push_back(1'($urandom_range(0, 1)));
    pulses = 0;
    tap_sel = 1;
    foreach (s[i]) begin
      if (i == abort_at) begin
        tap_sel = 0; tap_vld = 1; tap_di = s[i];
        tick();
        tap_vld = 0;
        return;
      end
      if (i == rst_at) begin
        rstb = 0; tap_vld = 1; tap_di = s[i];
        tick();
        rstb = 1; tap_vld = 0;
        return;
      end
      drive_bit(s[i]);
    end
  endtask

  task automatic tail();
    repeat (3) tick();
  endtask

  task automatic drop();
    tap_sel = 0;
    repeat (2) tick();
  endtask

  initial begin
    repeat (3) tick();
    chk1("reset_mode_scan", mode_scan, 1'b0);
    chk1("reset_mode_iddq", mode_iddq, 1'b0);
    chk1("reset_scan_vld", scan_vld, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_err", err, 1'b0);
    rstb = 1;
    tick();

    // Iddq entry with 10 payload bits
    session(KEY, 3'd2, 10, 10, 0, -1, -1);
    tail();
    chk("iddq_mode", int'(mode_iddq), 1);
    chk("iddq_no_scan", int'(mode_scan), 0);
    chk("iddq_hold_busy", int'(busy), 1);
    chk("iddq_pulses", pulses, 10);
    drop();

    // Wrong key: sticky err through the first idle cycle
    session(8'hA4, 3'd1, 3, 3, 0, -1, -1);
    tail();
    chk("badkey_err", int'(err), 1);
    chk("badkey_mode", int'(mode_scan | mode_iddq), 0);
    tap_sel = 0;
    tick();
    chk("badkey_err_kept", int'(err), 1);
    chk("badkey_idle", int'(busy), 0);
    tick();
    chk("badkey_err_clr", int'(err), 0);

    session(KEY, 3'd5, 4, 4, 0, -1, -1);
    tail();
    chk("badmode_err", int'(err), 1);
    drop();

    // Length 0 goes straight to hold; trailing bits are ignored
    session(KEY, 3'd1, 0, 3, 0, -1, -1);
    tail();
    chk("len0_scan", int'(mode_scan), 1);
    chk("len0_pulses", pulses, 0);
    drop();

    // Abort with the 6th payload strobe
    session(KEY, 3'd2, 10, 10, 0, HDR + 5, -1);
    chk("abort_iddq", int'(mode_iddq), 0);
    chk("abort_busy", int'(busy), 0);
    tail();
    chk("abort_pulses", pulses, 5);

    // Abort on the last length bit wins
    session(KEY, 3'd1, 4, 4, 0, 11 + LW - 1, -1);
    tail();
    chk("abort_len_mode", int'(mode_scan | mode_iddq), 0);

    // Reset mid-shift, then a fresh session
    session(KEY, 3'd2, 10, 10, 0, -1, HDR + 4);
    chk("rst_outs", int'({mode_scan, mode_iddq, scan_do, scan_vld, busy, err}), 0);
    drop();
    session(KEY, 3'd2, 10, 10, 0, -1, -1);
    tail();
    chk("rst_fresh_iddq", int'(mode_iddq), 1);
    chk("rst_fresh_pulses", pulses, 10);
    drop();

`ifdef TAP_PARITY_EN
    session(KEY, 3'd2, 10, 10, 1, -1, -1);
    tail();
    chk("par_bad_err", int'(err), 1);
    chk("par_bad_mode", int'(mode_scan | mode_iddq), 0);
    drop();
`endif

    for (int n = 0; n < 40; n++) begin
      logic [7:0] k;
      logic [2:0] c;
      int len, ab, rs;
      k = ($urandom_range(0, 5) == 0) ? 8'($urandom) : KEY;
      c = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(1, 2));
      len = $urandom_range(0, 12);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, HDR + len) : -1;
      rs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, HDR + len) : -1;
      session(k, c, len, len + $urandom_range(0, 2), ($urandom_range(0, 5) == 0), ab, rs);
      tail();
      drop();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
